// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and constants for the accelerator memory path
package acc_pkg;

  localparam int WORDS_PER_LINE = 16;
  localparam int IDX_W          = $clog2(WORDS_PER_LINE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  // Base byte addresses of the header and accumulator control blocks
  localparam logic [15:0] HCB_START_ADDR = 16'h1000;
  localparam logic [15:0] ACB_START_ADDR = 16'h5000;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DRAIN,
    RD_RESP,
    WR
  } arb_state_t;

endpackage

// File: rtl/acc_line_assembler.sv
// rtl/acc_line_assembler.sv - read tag pipe and 16-word line capture register
module acc_line_assembler
  import acc_pkg::*;
#(
  parameter int WORD_SIZE        = 32,
  parameter int LINE_SIZE        = 512,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_valid,
  input  logic [IDX_W-1:0]     push_idx,
  input  logic [WORD_SIZE-1:0] rd_data,
  output logic                 tag_valid,
  output logic [IDX_W-1:0]     tag_idx,
  output logic [LINE_SIZE-1:0] line
);

  // Tag for word k travels alongside the memory read latency
  logic [MEM_READ_LATENCY-1:0] pipe_v;
  logic [IDX_W-1:0]            pipe_idx [MEM_READ_LATENCY];

  assign tag_valid = pipe_v[MEM_READ_LATENCY-1];
  assign tag_idx   = pipe_idx[MEM_READ_LATENCY-1];

  // Shift the tag pipe every cycle; idle cycles push an invalid tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < MEM_READ_LATENCY; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= push_valid;
      pipe_idx[0] <= push_idx;
      for (int i = 1; i < MEM_READ_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Drop returning read data into its word slot when its tag emerges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= '0;
    end else if (tag_valid) begin
      line[int'(tag_idx)*WORD_SIZE +: WORD_SIZE] <= rd_data;
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// rtl/acc_mem_arbiter.sv - CPU-priority arbiter sharing data memory with the accelerator
module acc_mem_arbiter
  import acc_pkg::*;
#(
  parameter int ADDR_SIZE        = 16,
  parameter int WORD_SIZE        = 32,
  parameter int LINE_SIZE        = 512,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] cpu_mem_addr,
  input  logic                 cpu_mem_rd_en,
  input  logic                 cpu_mem_wr_en,
  input  logic [WORD_SIZE-1:0] cpu_mem_wr_data,
  output logic [WORD_SIZE-1:0] cpu_mem_rd_data,
  output logic [ADDR_SIZE-1:0] mem_listen_addr,
  output logic                 mem_listen_en,
  output logic [WORD_SIZE-1:0] mem_listen_data,
  input  logic                 mem_acc_read_en,
  input  logic [ADDR_SIZE-1:0] mem_acc_read_addr,
  output logic [LINE_SIZE-1:0] mem_acc_read_data,
  output logic                 mem_acc_read_data_valid,
  input  logic                 mem_acc_write_en,
  input  logic [ADDR_SIZE-1:0] mem_acc_write_addr,
  input  logic [WORD_SIZE-1:0] mem_acc_write_data,
  output logic                 mem_acc_write_done,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [WORD_SIZE-1:0] mem_wr_data,
  input  logic [WORD_SIZE-1:0] mem_rd_data
);

  arb_state_t             state, state_nxt;
  logic [ADDR_SIZE-1:0]   base_addr;
  logic [IDX_W-1:0]       word_cnt;
  logic [ADDR_SIZE-1:0]   wr_addr_q;
  logic [WORD_SIZE-1:0]   wr_data_q;
  logic                   cpu_active;
  logic                   rd_issue;
  logic                   tag_valid;
  logic [IDX_W-1:0]       tag_idx;

  assign cpu_active      = cpu_mem_rd_en | cpu_mem_wr_en;
  assign cpu_mem_rd_data = mem_rd_data;
  assign mem_listen_addr = cpu_mem_addr;
  assign mem_listen_en   = cpu_mem_wr_en;
  assign mem_listen_data = cpu_mem_wr_data;

  acc_line_assembler #(
    .WORD_SIZE        (WORD_SIZE),
    .LINE_SIZE        (LINE_SIZE),
    .MEM_READ_LATENCY (MEM_READ_LATENCY)
  ) u_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (rd_issue),
    .push_idx   (word_cnt),
    .rd_data    (mem_rd_data),
    .tag_valid  (tag_valid),
    .tag_idx    (tag_idx),
    .line       (mem_acc_read_data)
  );

  // State register plus request latches taken only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_addr <= '0;
      word_cnt  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mem_acc_read_en) begin
        base_addr <= mem_acc_read_addr;
        word_cnt  <= '0;
      end else if (state == IDLE && mem_acc_write_en) begin
        wr_addr_q <= mem_acc_write_addr;
        wr_data_q <= mem_acc_write_data;
      end
      if (rd_issue) word_cnt <= word_cnt + 1'b1;
    end
  end

  // Next state and memory port mux; a CPU request overrides any acc access
  always_comb begin
    state_nxt               = state;
    mem_addr                = '0;
    mem_rd_en               = 1'b0;
    mem_wr_en               = 1'b0;
    mem_wr_data             = '0;
    rd_issue                = 1'b0;
    mem_acc_read_data_valid = 1'b0;
    mem_acc_write_done      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_acc_read_en)       state_nxt = RD_ISSUE;
        else if (mem_acc_write_en) state_nxt = WR;
      end
      RD_ISSUE: begin
        if (!cpu_active) begin
          rd_issue  = 1'b1;
          mem_rd_en = 1'b1;
          mem_addr  = base_addr + ADDR_SIZE'({word_cnt, 2'b00});
          if (word_cnt == LAST_IDX) state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (tag_valid && tag_idx == LAST_IDX) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        mem_acc_read_data_valid = 1'b1;
        state_nxt               = IDLE;
      end
      WR: begin
        if (!cpu_active) begin
          mem_wr_en          = 1'b1;
          mem_addr           = wr_addr_q;
          mem_wr_data        = wr_data_q;
          mem_acc_write_done = 1'b1;
          state_nxt          = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (cpu_active) begin
      mem_addr    = cpu_mem_addr;
      mem_rd_en   = cpu_mem_rd_en;
      mem_wr_en   = cpu_mem_wr_en;
      mem_wr_data = cpu_mem_wr_data;
    end
  end

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb/tb_acc_mem_arbiter.sv - self-checking bench for acc_mem_arbiter at read latencies 1 and 3
module tb_acc_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0]  cpu_addr  [2];
  logic         cpu_rd    [2];
  logic         cpu_wr    [2];
  logic [31:0]  cpu_wdata [2];
  logic [31:0]  cpu_rdata [2];
  logic [15:0]  l_addr    [2];
  logic         l_en      [2];
  logic [31:0]  l_data    [2];
  logic         acc_rd    [2];
  logic [15:0]  acc_raddr [2];
  logic [511:0] acc_line  [2];
  logic         acc_vld   [2];
  logic         acc_wr    [2];
  logic [15:0]  acc_waddr [2];
  logic [31:0]  acc_wdata [2];
  logic         acc_done  [2];
  logic [15:0]  m_addr    [2];
  logic         m_rd      [2];
  logic         m_wr      [2];
  logic [31:0]  m_wdata   [2];
  logic [31:0]  m_rdata   [2];

  acc_mem_arbiter #(.MEM_READ_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_addr(cpu_addr[0]), .cpu_mem_rd_en(cpu_rd[0]), .cpu_mem_wr_en(cpu_wr[0]),
    .cpu_mem_wr_data(cpu_wdata[0]), .cpu_mem_rd_data(cpu_rdata[0]),
    .mem_listen_addr(l_addr[0]), .mem_listen_en(l_en[0]), .mem_listen_data(l_data[0]),
    .mem_acc_read_en(acc_rd[0]), .mem_acc_read_addr(acc_raddr[0]),
    .mem_acc_read_data(acc_line[0]), .mem_acc_read_data_valid(acc_vld[0]),
    .mem_acc_write_en(acc_wr[0]), .mem_acc_write_addr(acc_waddr[0]),
    .mem_acc_write_data(acc_wdata[0]), .mem_acc_write_done(acc_done[0]),
    .mem_addr(m_addr[0]), .mem_rd_en(m_rd[0]), .mem_wr_en(m_wr[0]),
    .mem_wr_data(m_wdata[0]), .mem_rd_data(m_rdata[0])
  );

  acc_mem_arbiter #(.MEM_READ_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_addr(cpu_addr[1]), .cpu_mem_rd_en(cpu_rd[1]), .cpu_mem_wr_en(cpu_wr[1]),
    .cpu_mem_wr_data(cpu_wdata[1]), .cpu_mem_rd_data(cpu_rdata[1]),
    .mem_listen_addr(l_addr[1]), .mem_listen_en(l_en[1]), .mem_listen_data(l_data[1]),
    .mem_acc_read_en(acc_rd[1]), .mem_acc_read_addr(acc_raddr[1]),
    .mem_acc_read_data(acc_line[1]), .mem_acc_read_data_valid(acc_vld[1]),
    .mem_acc_write_en(acc_wr[1]), .mem_acc_write_addr(acc_waddr[1]),
    .mem_acc_write_data(acc_wdata[1]), .mem_acc_write_done(acc_done[1]),
    .mem_addr(m_addr[1]), .mem_rd_en(m_rd[1]), .mem_wr_en(m_wr[1]),
    .mem_wr_data(m_wdata[1]), .mem_rd_data(m_rdata[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Memory contents and read-data delay line per instance
  logic [31:0]  mem [2][16384];
  logic [31:0]  dq  [2][3];

  // Transaction-level view of each arbiter: 0 idle, 1 line read, 2 word write
  int           md       [2];
  logic [15:0]  mbase    [2];
  int           missued  [2];
  int           mpulse   [2];
  logic [31:0]  mline    [2][16];
  logic [511:0] mreg     [2];
  logic [15:0]  mwa      [2];
  logic [31:0]  mwd      [2];

  int           pulse_at   [2];
  logic [511:0] pulse_line [2];
  int           done_cnt   [2];
  int           done_at    [2];
  int           listen_cnt [2];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    logic         cact;
    logic [15:0]  e_addr;
    logic         e_rd, e_wr, e_vld, e_done;
    logic [31:0]  e_wd;
    logic [511:0] e_line;
    cact = cpu_rd[i] | cpu_wr[i];
    if (rst_n !== 1'b1) begin
      md[i] = 0; missued[i] = 0; mpulse[i] = -1; mreg[i] = '0;
    end
    e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_wd = '0; e_done = 1'b0;
    if (cact) begin
      e_addr = cpu_addr[i]; e_rd = cpu_rd[i]; e_wr = cpu_wr[i]; e_wd = cpu_wdata[i];
    end else if (md[i] == 1 && missued[i] < 16) begin
      e_addr = mbase[i] + 16'(4 * missued[i]); e_rd = 1'b1;
    end else if (md[i] == 2) begin
      e_addr = mwa[i]; e_wr = 1'b1; e_wd = mwd[i]; e_done = 1'b1;
    end
    e_vld = (md[i] == 1 && cyc == mpulse[i]);
    for (int k = 0; k < 16; k++) e_line[32*k +: 32] = mline[i][k];

    chk($sformatf("dut%0d c%0d mem_addr", i, cyc), m_addr[i], e_addr);
    chk($sformatf("dut%0d c%0d mem_rd_en", i, cyc), m_rd[i], e_rd);
    chk($sformatf("dut%0d c%0d mem_wr_en", i, cyc), m_wr[i], e_wr);
    chk($sformatf("dut%0d c%0d mem_wr_data", i, cyc), m_wdata[i], e_wd);
    chk($sformatf("dut%0d c%0d read_valid", i, cyc), acc_vld[i], e_vld);
    chk($sformatf("dut%0d c%0d write_done", i, cyc), acc_done[i], e_done);
    chk($sformatf("dut%0d c%0d listen_addr", i, cyc), l_addr[i], cpu_addr[i]);
    chk($sformatf("dut%0d c%0d listen_en", i, cyc), l_en[i], cpu_wr[i]);
    chk($sformatf("dut%0d c%0d listen_data", i, cyc), l_data[i], cpu_wdata[i]);
    chk($sformatf("dut%0d c%0d cpu_rd_data", i, cyc), cpu_rdata[i], m_rdata[i]);
    if (e_vld) chk($sformatf("dut%0d c%0d line_at_valid", i, cyc), acc_line[i], e_line);
    if (md[i] == 0) chk($sformatf("dut%0d c%0d line_idle", i, cyc), acc_line[i], mreg[i]);

    if (acc_vld[i] === 1'b1) begin pulse_at[i] = cyc; pulse_line[i] = acc_line[i]; end
    if (acc_done[i] === 1'b1) begin done_cnt[i]++; done_at[i] = cyc; end
    if (l_en[i] === 1'b1) listen_cnt[i]++;

    case (md[i])
      0: if (rst_n === 1'b1) begin
        if (acc_rd[i]) begin
          md[i] = 1; mbase[i] = acc_raddr[i]; missued[i] = 0; mpulse[i] = -1;
        end else if (acc_wr[i]) begin
          md[i] = 2; mwa[i] = acc_waddr[i]; mwd[i] = acc_wdata[i];
        end
      end
      1: begin
        if (!cact && missued[i] < 16) begin
          mline[i][missued[i]] = mem[i][e_addr[15:2]];
          missued[i]++;
          if (missued[i] == 16) mpulse[i] = cyc + lat(i) + 1;
        end
        if (e_vld) begin md[i] = 0; mreg[i] = e_line; end
      end
      2: if (!cact) md[i] = 0;
      default: md[i] = 0;
    endcase

    for (int j = 2; j > 0; j--) dq[i][j] = dq[i][j-1];
    dq[i][0] = (m_rd[i] === 1'b1) ? mem[i][m_addr[i][15:2]] : 32'h0;
    if (m_wr[i] === 1'b1) mem[i][m_addr[i][15:2]] = m_wdata[i];
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) m_rdata[i] = dq[i][lat(i)-1];
  endtask

  task automatic fill(input int i, input logic [15:0] base, input logic [31:0] pat);
    logic [15:0] wa;
    for (int k = 0; k < 16; k++) begin
      wa = base + 16'(4 * k);
      mem[i][wa[15:2]] = pat + 32'(k);
    end
  endtask

  task automatic run_read(input int i, input logic [15:0] a, input int cfrom, input int cto,
                          output int lat_o);
    int s;
    pulse_at[i] = -1; acc_raddr[i] = a; acc_rd[i] = 1'b1; cpu_addr[i] = 16'h0100;
    s = cyc;
    for (int n = 0; n < 80 && pulse_at[i] < 0; n++) begin
      cpu_rd[i] = (cyc - s >= cfrom) && (cyc - s <= cto);
      tick();
    end
    acc_rd[i] = 1'b0; cpu_rd[i] = 1'b0;
    lat_o = (pulse_at[i] < 0) ? -1 : pulse_at[i] - s;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           l;
    int           s;
    logic [511:0] line1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cpu_addr[i] = '0; cpu_rd[i] = 1'b0; cpu_wr[i] = 1'b0; cpu_wdata[i] = '0;
      acc_rd[i] = 1'b0; acc_raddr[i] = '0; acc_wr[i] = 1'b0; acc_waddr[i] = '0; acc_wdata[i] = '0;
      m_rdata[i] = '0; md[i] = 0; mbase[i] = '0; missued[i] = 0; mpulse[i] = -1;
      mreg[i] = '0; mwa[i] = '0; mwd[i] = '0; pulse_at[i] = -1; pulse_line[i] = '0;
      done_cnt[i] = 0; done_at[i] = -1; listen_cnt[i] = 0;
      for (int j = 0; j < 3; j++) dq[i][j] = '0;
      for (int k = 0; k < 16; k++) mline[i][k] = '0;
      for (int w = 0; w < 16384; w++) mem[i][w] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Line read with the CPU idle
    fill(0, 16'h1010, 32'hA000_0000);
    run_read(0, 16'h1010, 1, 0, l);
    chk("t1_valid_cycle", l, 18);
    chk("t1_word0", pulse_line[0][31:0], 32'hA000_0000);
    chk("t1_word15", pulse_line[0][511:480], 32'hA000_000F);
    line1 = pulse_line[0];
    repeat (2) tick();

    // Same read with CPU reads stealing cycles 5-8
    mem[0][16'h0100 >> 2] = 32'h1234_5678;
    run_read(0, 16'h1010, 5, 8, l);
    chk("t2_valid_cycle", l, 22);
    chk("t2_line", pulse_line[0], line1);
    repeat (2) tick();

    // Eight back-to-back hash word writes
    done_cnt[0] = 0;
    s = cyc;
    for (int j = 0; j < 8; j++) begin
      acc_waddr[0] = 16'h5008 + 16'(4 * j); acc_wdata[0] = 32'hDEAD_BEEF; acc_wr[0] = 1'b1;
      for (int n = 0; n < 10 && done_cnt[0] == j; n++) tick();
    end
    acc_wr[0] = 1'b0;
    chk("t3_done_count", done_cnt[0], 8);
    chk("t3_last_done_cycle", done_at[0] - s, 15);
    chk("t3_mem_5008", mem[0][16'h5008 >> 2], 32'hDEAD_BEEF);
    chk("t3_mem_5024", mem[0][16'h5024 >> 2], 32'hDEAD_BEEF);
    chk("t3_mem_5028", mem[0][16'h5028 >> 2], 32'h0);
    tick();

    // CPU and accelerator write the same word in the same cycle
    listen_cnt[0] = 0; done_at[0] = -1;
    cpu_addr[0] = 16'h5000; cpu_wdata[0] = 32'h1; cpu_wr[0] = 1'b1;
    acc_waddr[0] = 16'h5000; acc_wdata[0] = 32'h2; acc_wr[0] = 1'b1;
    s = cyc;
    tick();
    cpu_wr[0] = 1'b0; cpu_wdata[0] = '0;
    chk("t4_mem_after_cpu", mem[0][16'h5000 >> 2], 32'h1);
    for (int n = 0; n < 5 && done_at[0] < 0; n++) tick();
    acc_wr[0] = 1'b0;
    tick();
    chk("t4_acc_done_cycle", done_at[0] - s, 1);
    chk("t4_final_mem", mem[0][16'h5000 >> 2], 32'h2);
    chk("t4_listen_count", listen_cnt[0], 1);

    // Asynchronous reset in cycle 9 of a burst
    pulse_at[0] = -1;
    acc_raddr[0] = 16'h1010; acc_rd[0] = 1'b1;
    repeat (9) tick();
    rst_n = 1'b0; acc_rd[0] = 1'b0;
    #1;
    chk("t5_async_rd_en", m_rd[0], 1'b0);
    chk("t5_async_line", acc_line[0], 512'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_pulse", pulse_at[0], -1);
    run_read(0, 16'h1010, 1, 0, l);
    chk("t5_restart_cycle", l, 18);
    chk("t5_restart_line", pulse_line[0], line1);
    tick();

    // Read latency 3 instance
    fill(1, 16'h1010, 32'hB000_0000);
    run_read(1, 16'h1010, 1, 0, l);
    chk("t6_valid_cycle", l, 20);
    chk("t6_word0", pulse_line[1][31:0], 32'hB000_0000);
    chk("t6_word15", pulse_line[1][511:480], 32'hB000_000F);
    tick();

    // Burst that wraps past the top of the address space
    fill(1, 16'hFFF0, 32'hC000_0000);
    run_read(1, 16'hFFF0, 1, 0, l);
    chk("wrap_valid_cycle", l, 20);
    chk("wrap_word4", pulse_line[1][159:128], 32'hC000_0004);
    chk("wrap_word15", pulse_line[1][511:480], 32'hC000_000F);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_mem_arbiter.md
Name: acc_mem_arbiter

Overview:
Shares the single-ported 32-bit data memory between the CPU and the accelerator control unit, sitting directly downstream of that control unit. It serves the control unit's 512-bit block-header reads as bursts of 16 word reads. It serves 32-bit hash and status writes as single word writes. The CPU always has priority. The block produces mem_acc_read_data_valid and mem_acc_write_done, and mirrors CPU writes onto the mem_listen_* MMIO snoop lines.

Parameters:
ADDR_SIZE, 16, byte address width on all ports
WORD_SIZE, 32, memory and CPU data width
LINE_SIZE, 512, accelerator read line width (LINE_SIZE/WORD_SIZE = 16 words)
MEM_READ_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpu_mem_addr  in  ADDR_SIZE  CPU byte address
cpu_mem_rd_en  in  1  CPU read request
cpu_mem_wr_en  in  1  CPU write request
cpu_mem_wr_data  in  WORD_SIZE  CPU write data
cpu_mem_rd_data  out  WORD_SIZE  CPU read data (mem_rd_data passthrough)
mem_listen_addr  out  ADDR_SIZE  = cpu_mem_addr
mem_listen_en  out  1  = cpu_mem_wr_en
mem_listen_data  out  WORD_SIZE  = cpu_mem_wr_data
mem_acc_read_en  in  1  accelerator line read request (level, held until valid)
mem_acc_read_addr  in  ADDR_SIZE  line base byte address
mem_acc_read_data  out  LINE_SIZE  assembled line
mem_acc_read_data_valid  out  1  one-cycle line-ready pulse
mem_acc_write_en  in  1  accelerator word write request (level, held until done)
mem_acc_write_addr  in  ADDR_SIZE  write byte address
mem_acc_write_data  in  WORD_SIZE  write data
mem_acc_write_done  out  1  one-cycle write-committed pulse
mem_addr  out  ADDR_SIZE  memory address
mem_rd_en  out  1  memory read strobe
mem_wr_en  out  1  memory write strobe
mem_wr_data  out  WORD_SIZE  memory write data
mem_rd_data  in  WORD_SIZE  memory read data

Behaviour:
- Reset: FSM goes to IDLE, counters and tag pipe clear, mem_acc_read_data = 0. valid and done are 0, and all mem_* outputs are 0.
- CPU priority: in any cycle with cpu_mem_rd_en or cpu_mem_wr_en high, mem_* carries the CPU request unchanged. The accelerator issues nothing that cycle, and its issue counter holds.
- mem_listen_* and cpu_mem_rd_data are combinational passthroughs and are unaffected by FSM state.
- FSM states: IDLE, RD_ISSUE, RD_DRAIN, RD_RESP, WR.
- IDLE:
  - mem_acc_read_en -> RD_ISSUE, latching the base address and clearing the word counter.
  - else mem_acc_write_en -> WR.
  - Read wins if both are high.
- RD_ISSUE:
  - Each CPU-free cycle issues word k at base + 4k (mem_rd_en = 1) and pushes tag {valid, k} into a MEM_READ_LATENCY-deep pipe.
  - After k = 15 is issued -> RD_DRAIN.
- Capture: when a pipe tag emerges valid, mem_rd_data is written to line bits [32k+31:32k]. Capture happens in any state.
- RD_DRAIN: when the last tag has been captured -> RD_RESP.
- RD_RESP: mem_acc_read_data_valid = 1 for exactly one cycle, then -> IDLE.
- Read latency with the CPU idle: the request is seen in IDLE at cycle 0, and valid rises in cycle 17 + MEM_READ_LATENCY. Each CPU-occupied cycle adds one cycle.
- mem_acc_read_data is registered and stable from the valid pulse until the next capture.
- WR:
  - In the first CPU-free cycle, drive mem_wr_en/mem_addr/mem_wr_data from the acc inputs and assert mem_acc_write_done in that same cycle, then -> IDLE.
  - Back-to-back writes take 2 cycles each.
- Address wrap: base + 4k wraps modulo 2^ADDR_SIZE.
- Request drop mid-operation: an accelerator request dropped before completion is ignored; the operation completes and the pulse is still issued.
- Requests are sampled only in IDLE.
- CPU write to an address inside an in-flight burst: CPU and acc accesses are serviced in cycle order, with no ordering check. If CPU and acc write the same address, the acc write lands last.
- Asynchronous reset mid-burst: the partial line is discarded and no pulse is produced.

Decomposition:
- Shared package acc_pkg:
  - arb_state_t enum
  - WORDS_PER_LINE
  - HCB_START_ADDR and ACB_START_ADDR, also used by the control unit
- Sub-module acc_line_assembler: the tag pipe plus the 16-word line register and its capture logic.

Test Plan:
1. CPU idle; acc read at 0x1010; memory word at 0x1010 + 4k = 0xA000_0000 + k -> single valid pulse at cycle 18 (L = 1); data[31:0] = 0xA0000000, data[511:480] = 0xA000000F.
2. Same as test 1 plus CPU reads of 0x0100 in cycles 5–8 -> mem_addr = 0x0100 in those cycles, CPU receives its data; valid at cycle 22 with an identical line.
3. Acc writes of 0xDEADBEEF to 0x5008..0x5024 (8 words, as WRITE_H0..H7) -> each done coincides with mem_wr_en at the correct address; all 8 done within 16 cycles.
4. CPU write of 0x1 and acc write of 0x2 to 0x5000 in the same cycle -> CPU write first, acc write next cycle, final memory value 0x2; mem_listen_en high only for the CPU write.
5. rst_n dropped at cycle 9 of a burst -> all outputs 0 immediately with no valid pulse; after release a new request starts again at word 0.
6. MEM_READ_LATENCY = 3 with the CPU idle -> valid at cycle 20, line correct.
